// File: rtl/pn_cmd_encoder.sv
// ---------------------------------------------------------------------------
// pn_cmd_encoder
//
// Host-side command encoder for the PN controller. Typed host requests
// (spikes and parameter writes to Synapse, SOMA, STDP and Rich Club) are
// accepted over a valid/ready port, queued in a FIFO, and issued one at a
// time as 16-bit address / 32-bit data words in the controller's decode
// format. Synapse writes at the FIFO head stall while SWU_EN is high.
//
// Build option:
//   PN_SPIKE_PAIR_EN - when defined, a spike waits up to PAIR_WIN cycles
//                      for a second spike and both issue as one word.
//                      When undefined, every spike issues on its own.
//
// Parameters:
//   FIFO_DEPTH - command FIFO entries (power of two, 2..64)
//   HOLD_CYC   - cycles each issued word stays on the outputs (1..15)
//   PAIR_WIN   - spike pairing window in cycles (1..15, pairing only)
//
// Ports:
//   clk         - clock
//   rst         - synchronous active-high reset
//   cmd_valid   - host request valid
//   cmd_ready   - encoder can accept a request (registered, !full)
//   cmd_type    - 0 spike, 1 Synapse, 2 SOMA, 3 STDP, 4 Rich Club, 5..7 illegal
//   cmd_addr    - neuron ID (spike) or parameter address
//   cmd_data    - write data (ignored for spikes)
//   SWU_EN      - synaptic weight update owns the Synapse port
//   to_PN_Addr  - address word; bit 15 mirrors to_PN_VALID
//   to_PN_DATA  - data word
//   to_PN_VALID - a word is being issued
//   busy        - FIFO not empty or FSM not idle
//   fifo_level  - FIFO occupancy
//   err_illegal - one-cycle pulse when an illegal type is accepted
// ---------------------------------------------------------------------------
module pn_cmd_encoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int HOLD_CYC   = 1,
    parameter int PAIR_WIN   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_type,
    input  logic [6:0]                    cmd_addr,
    input  logic [31:0]                   cmd_data,
    input  logic                          SWU_EN,
    output logic [15:0]                   to_PN_Addr,
    output logic [31:0]                   to_PN_DATA,
    output logic                          to_PN_VALID,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          err_illegal
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
    localparam logic [3:0]    HOLD_LAST  = 4'(HOLD_CYC - 1);

    localparam logic [2:0] T_SPIKE = 3'd0;
    localparam logic [2:0] T_SYN   = 3'd1;
    localparam logic [2:0] T_SOMA  = 3'd2;
    localparam logic [2:0] T_STDP  = 3'd3;
    localparam logic [2:0] T_RICH  = 3'd4;

    // Parameter range checks, evaluated at elaboration.
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pn_cmd_encoder: FIFO_DEPTH must be a power of two in 2..64");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
        $error("pn_cmd_encoder: HOLD_CYC must be in 1..15");
    end
    if (PAIR_WIN < 1 || PAIR_WIN > 15) begin : g_bad_pair
        $error("pn_cmd_encoder: PAIR_WIN must be in 1..15");
    end

    typedef struct packed {
        logic [2:0]  typ;
        logic [6:0]  addr;
        logic [31:0] data;
    } entry_t;

`ifdef PN_SPIKE_PAIR_EN
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_PAIR_WAIT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1
    } state_t;
`endif

    // Parameter-write address bits 14:0: type flag, target select, zero pad, address.
    function automatic logic [14:0] param_word(input logic [2:0] typ, input logic [6:0] addr);
        logic [1:0] sel;
        case (typ)
            T_SYN:   sel = 2'b01;
            T_SOMA:  sel = 2'b10;
            T_STDP:  sel = 2'b11;
            T_RICH:  sel = 2'b00;
            default: sel = 2'b00;
        endcase
        return {1'b1, sel, 5'b0_0000, addr};
    endfunction

    // Spike address bits 14:0: type flag, second neuron ID, first neuron ID.
    function automatic logic [14:0] spike_word(input logic [6:0] second, input logic [6:0] first);
        return {1'b0, second, first};
    endfunction

    // ---------------------------------------------------------------------
    // Command FIFO
    // ---------------------------------------------------------------------
    entry_t        r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_count;

    logic          r_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [LW-1:0] w_count_next;
    entry_t        w_head;
    logic          w_head_spike;
    logic          w_head_illegal;
    logic          w_in_illegal;

    assign w_push         = cmd_valid && r_ready;
    assign w_empty        = (r_count == '0);
    assign w_head         = r_mem[r_rd_ptr];
    assign w_head_spike   = (w_head.typ == T_SPIKE);
    assign w_head_illegal = (w_head.typ > T_RICH);
    assign w_in_illegal   = (cmd_type > T_RICH);
    assign w_count_next   = r_count + LW'(w_push) - LW'(w_pop);

    // NOTE: storage is not reset; the pointers and count define which entries
    // are live, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{typ: cmd_type, addr: cmd_addr, data: cmd_data};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
        end
    end

    // ---------------------------------------------------------------------
    // Issue FSM
    // ---------------------------------------------------------------------
    state_t        r_state;
    state_t        w_state_next;
    logic          w_issue;
    logic [14:0]   w_word_lo;
    logic [31:0]   w_word_data;

    logic          r_valid;
    logic [14:0]   r_word_lo;
    logic [31:0]   r_data;
    logic [3:0]    r_hold_cnt;
    logic          r_busy;
    logic          r_err;

`ifdef PN_SPIKE_PAIR_EN
    localparam logic [3:0] PAIR_LAST = 4'(PAIR_WIN - 1);
    logic [6:0]    r_pair_first;
    logic [3:0]    r_pair_cnt;
`endif

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_issue      = 1'b0;
        w_word_lo    = '0;
        w_word_data  = '0;
        case (r_state)
            S_IDLE: begin
                // A Synapse write at the head waits out the weight update;
                // other head types are unaffected by SWU_EN.
                if (!w_empty && !(w_head.typ == T_SYN && SWU_EN)) begin
                    w_pop = 1'b1;
                    if (w_head_spike) begin
`ifdef PN_SPIKE_PAIR_EN
                        w_state_next = S_PAIR_WAIT;
`else
                        w_issue   = 1'b1;
                        w_word_lo = spike_word(7'd0, w_head.addr);
`endif
                    end else if (!w_head_illegal) begin
                        w_issue     = 1'b1;
                        w_word_lo   = param_word(w_head.typ, w_head.addr);
                        w_word_data = w_head.data;
                    end
                    // An illegal head is popped and dropped without issuing.
                end
            end
`ifdef PN_SPIKE_PAIR_EN
            S_PAIR_WAIT: begin
                if (!w_empty && w_head_spike && !(r_pair_first == 7'd0 && w_head.addr == 7'd0)) begin
                    w_pop   = 1'b1;
                    w_issue = 1'b1;
                    // A zero second ID would read as a single spike, so the
                    // IDs are swapped to keep the word a genuine pair.
                    if (w_head.addr == 7'd0) begin
                        w_word_lo = spike_word(r_pair_first, 7'd0);
                    end else begin
                        w_word_lo = spike_word(w_head.addr, r_pair_first);
                    end
                end else if (!w_empty || r_pair_cnt == PAIR_LAST) begin
                    // Head is not a usable partner, or the window expired.
                    w_issue   = 1'b1;
                    w_word_lo = spike_word(7'd0, r_pair_first);
                end
            end
`endif
            S_ISSUE: begin
                if (r_hold_cnt == HOLD_LAST) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (w_issue) begin
            w_state_next = S_ISSUE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_valid    <= 1'b0;
            r_word_lo  <= '0;
            r_data     <= '0;
            r_hold_cnt <= '0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
            r_err      <= 1'b0;
`ifdef PN_SPIKE_PAIR_EN
            r_pair_first <= '0;
            r_pair_cnt   <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            // Status outputs describe the state after this edge.
            r_busy  <= (w_count_next != '0) || (w_state_next != S_IDLE);
            r_ready <= (w_count_next != LEVEL_FULL);
            r_err   <= w_push && w_in_illegal;

            // The word is loaded on the pop edge so valid rises one edge
            // after acceptance when the FIFO was empty.
            if (w_issue) begin
                r_valid    <= 1'b1;
                r_word_lo  <= w_word_lo;
                r_data     <= w_word_data;
                r_hold_cnt <= '0;
            end else if (r_state == S_ISSUE) begin
                if (w_state_next == S_IDLE) begin
                    r_valid   <= 1'b0;
                    r_word_lo <= '0;
                    r_data    <= '0;
                end else begin
                    r_hold_cnt <= r_hold_cnt + 4'd1;
                end
            end

`ifdef PN_SPIKE_PAIR_EN
            if (r_state == S_IDLE && w_state_next == S_PAIR_WAIT) begin
                r_pair_first <= w_head.addr;
                r_pair_cnt   <= '0;
            end else if (r_state == S_PAIR_WAIT && w_state_next == S_PAIR_WAIT) begin
                r_pair_cnt <= r_pair_cnt + 4'd1;
            end
`endif
        end
    end

    assign cmd_ready   = r_ready;
    assign to_PN_VALID = r_valid;
    assign to_PN_Addr  = {r_valid, r_word_lo};
    assign to_PN_DATA  = r_data;
    assign busy        = r_busy;
    assign fifo_level  = r_count;
    assign err_illegal = r_err;

endmodule

// File: tb/tb_pn_cmd_encoder.sv
// ---------------------------------------------------------------------------
// tb_pn_cmd_encoder
//
// Directed bench for pn_cmd_encoder with hand-computed expected words.
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// at that same point, and a monitor on the falling edge records every word
// whose valid rises. Expectations follow PN_SPIKE_PAIR_EN when defined.
// ---------------------------------------------------------------------------
module tb_pn_cmd_encoder;

    localparam int FIFO_DEPTH = 8;
    localparam int HOLD_CYC   = 2;
    localparam int PAIR_WIN   = 4;

`ifdef PN_SPIKE_PAIR_EN
    localparam int EXP_SPIKE_LAT = 1 + PAIR_WIN;
`else
    localparam int EXP_SPIKE_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_type = '0;
    logic [6:0]  cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic        SWU_EN = 1'b0;
    logic [15:0] to_PN_Addr;
    logic [31:0] to_PN_DATA;
    logic        to_PN_VALID;
    logic        busy;
    logic [3:0]  fifo_level;
    logic        err_illegal;

    always #5 clk = ~clk;

    pn_cmd_encoder #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .HOLD_CYC   (HOLD_CYC),
        .PAIR_WIN   (PAIR_WIN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_type    (cmd_type),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .SWU_EN      (SWU_EN),
        .to_PN_Addr  (to_PN_Addr),
        .to_PN_DATA  (to_PN_DATA),
        .to_PN_VALID (to_PN_VALID),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .err_illegal (err_illegal)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [47:0] mon_q [$];
    logic [47:0] exp_q [$];
    logic        mon_prev = 1'b0;

    always @(negedge clk) begin
        if (to_PN_VALID === 1'b1 && mon_prev !== 1'b1) begin
            mon_q.push_back({to_PN_Addr, to_PN_DATA});
        end
        mon_prev = to_PN_VALID;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic push_cmd(input logic [2:0] t, input logic [6:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_addr  = a;
        cmd_data  = d;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic expect_word(input logic [15:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic compare_words(input string tag);
        check($sformatf("%s_count", tag), 32'(mon_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < mon_q.size()) begin
                check($sformatf("%s_addr%0d", tag, i), 32'(mon_q[i][47:32]), 32'(exp_q[i][47:32]));
                check($sformatf("%s_data%0d", tag, i), mon_q[i][31:0], exp_q[i][31:0]);
            end
        end
        mon_q.delete();
        exp_q.delete();
    endtask

    // Full-FIFO stimulus: types, with type 6 illegal in slot 4.
    logic [2:0] full_types [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd0, 3'd2, 3'd1};

    initial begin
        int lat;

        // ---------------- reset state ----------------
        run(3);
        rst = 1'b0;
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_valid", 32'(to_PN_VALID), 32'd0);
        check("rst_addr", 32'(to_PN_Addr), 32'h0);
        check("rst_data", to_PN_DATA, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_err", 32'(err_illegal), 32'd0);

        // ---------------- SOMA write, exact timing ----------------
        push_cmd(3'd2, 7'h05, 32'hDEAD_BEEF);
        check("soma_n_level", 32'(fifo_level), 32'd1);
        check("soma_n_valid", 32'(to_PN_VALID), 32'd0);
        check("soma_n_busy", 32'(busy), 32'd1);
        step();
        check("soma_n1_valid", 32'(to_PN_VALID), 32'd1);
        check("soma_n1_addr", 32'(to_PN_Addr), 32'hE005);
        check("soma_n1_data", to_PN_DATA, 32'hDEAD_BEEF);
        check("soma_n1_level", 32'(fifo_level), 32'd0);
        step();
        check("soma_n2_valid", 32'(to_PN_VALID), 32'd1);
        step();
        check("soma_n3_valid", 32'(to_PN_VALID), 32'd0);
        check("soma_n3_addr", 32'(to_PN_Addr), 32'h0);
        check("soma_n3_busy", 32'(busy), 32'd0);
        expect_word(16'hE005, 32'hDEAD_BEEF);
        compare_words("soma");

        // ---------------- Synapse stall under SWU_EN ----------------
        SWU_EN = 1'b1;
        push_cmd(3'd1, 7'h12, 32'h1122_3344);
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("swu_stall%0d_valid", i), 32'(to_PN_VALID), 32'd0);
            check($sformatf("swu_stall%0d_busy", i), 32'(busy), 32'd1);
        end
        SWU_EN = 1'b0;
        step();
        check("swu_rel_valid", 32'(to_PN_VALID), 32'd1);
        check("swu_rel_addr", 32'(to_PN_Addr), 32'hD012);
        // A rise of SWU_EN during the issue must not abort the word.
        SWU_EN = 1'b1;
        step();
        check("swu_hold_valid", 32'(to_PN_VALID), 32'd1);
        step();
        SWU_EN = 1'b0;
        check("swu_end_valid", 32'(to_PN_VALID), 32'd0);
        expect_word(16'hD012, 32'h1122_3344);
        compare_words("swu");

        // ---------------- spikes 3 then 9 ----------------
        push_cmd(3'd0, 7'd3, 32'hFFFF_FFFF);
        push_cmd(3'd0, 7'd9, 32'hFFFF_FFFF);
        run(20);
`ifdef PN_SPIKE_PAIR_EN
        expect_word(16'h8483, 32'h0);
`else
        expect_word(16'h8003, 32'h0);
        expect_word(16'h8009, 32'h0);
`endif
        compare_words("spk39");

        // ---------------- spikes 0 then 7, 5 then 0 ----------------
        push_cmd(3'd0, 7'd0, 32'h0);
        push_cmd(3'd0, 7'd7, 32'h0);
        run(20);
        push_cmd(3'd0, 7'd5, 32'h0);
        push_cmd(3'd0, 7'd0, 32'h0);
        run(20);
`ifdef PN_SPIKE_PAIR_EN
        expect_word(16'h8380, 32'h0);
        expect_word(16'h8280, 32'h0);
`else
        expect_word(16'h8000, 32'h0);
        expect_word(16'h8007, 32'h0);
        expect_word(16'h8005, 32'h0);
        expect_word(16'h8000, 32'h0);
`endif
        compare_words("spk_zero");

        // ---------------- lone spike latency ----------------
        push_cmd(3'd0, 7'd5, 32'h0);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (to_PN_VALID === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("lone_spk_latency", 32'(lat), 32'(EXP_SPIKE_LAT));
        check("lone_spk_addr", 32'(to_PN_Addr), 32'h8005);
        run(5);
        expect_word(16'h8005, 32'h0);
        compare_words("lone");

        // ---------------- FIFO full, ordering, illegal drop ----------------
        SWU_EN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_cmd(full_types[i], 7'(i + 1), 32'hA000_0000 + 32'(i));
            check($sformatf("full_push%0d_level", i), 32'(fifo_level), 32'(i + 1));
            check($sformatf("full_push%0d_err", i), 32'(err_illegal), (i == 4) ? 32'd1 : 32'd0);
        end
        check("full_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b1;
        cmd_type  = 3'd2;
        cmd_addr  = 7'd9;
        cmd_data  = 32'hA000_0008;
        run(3);
        check("full_held_level", 32'(fifo_level), 32'd8);
        check("full_held_ready", 32'(cmd_ready), 32'd0);
        SWU_EN = 1'b0;
        step();
        check("full_pop_level", 32'(fifo_level), 32'd7);
        check("full_pop_ready", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        check("full_9th_level", 32'(fifo_level), 32'd8);
        run(60);
        check("full_drain_level", 32'(fifo_level), 32'd0);
        check("full_drain_busy", 32'(busy), 32'd0);
        expect_word(16'hD001, 32'hA000_0000);
        expect_word(16'hE002, 32'hA000_0001);
        expect_word(16'hF003, 32'hA000_0002);
        expect_word(16'hC004, 32'hA000_0003);
        expect_word(16'h8006, 32'h0);
        expect_word(16'hE007, 32'hA000_0006);
        expect_word(16'hD008, 32'hA000_0007);
        expect_word(16'hE009, 32'hA000_0008);
        compare_words("full");

        // ---------------- reset during issue ----------------
        SWU_EN = 1'b1;
        push_cmd(3'd1, 7'h21, 32'hB000_0001);
        push_cmd(3'd2, 7'h22, 32'hB000_0002);
        push_cmd(3'd2, 7'h23, 32'hB000_0003);
        push_cmd(3'd2, 7'h24, 32'hB000_0004);
        SWU_EN = 1'b0;
        step();
        check("mid_rst_pre_valid", 32'(to_PN_VALID), 32'd1);
        check("mid_rst_pre_level", 32'(fifo_level), 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", 32'(to_PN_VALID), 32'd0);
        check("mid_rst_addr", 32'(to_PN_Addr), 32'h0);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        run(10);
        check("post_rst_level", 32'(fifo_level), 32'd0);
        expect_word(16'hD021, 32'hB000_0001);
        compare_words("mid_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
